// File: rtl/hps_timer_scheduler.sv
// Prescaled 32-bit timebase with NUM_CH one-shot/periodic alarms and a round-robin event slot.
// Optional macro SCHED_OVERRUN_CNT_EN adds per-channel saturating 8-bit overrun counters.
module hps_timer_scheduler #(
   parameter int unsigned PRESCALE = 5000,
   parameter int unsigned NUM_CH   = 4,
   localparam int unsigned CH_W    = $clog2(NUM_CH)
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_cfg_wr,
   input  logic [CH_W-1:0]     i_cfg_ch,
   input  logic                i_cfg_enable,
   input  logic                i_cfg_periodic,
   input  logic [31:0]         i_cfg_period,
   output logic                o_tick,
   output logic [31:0]         o_timebase,
   output logic                o_evt_valid,
   input  logic                i_evt_ready,
   output logic [CH_W-1:0]     o_evt_ch,
   output logic [31:0]         o_evt_time,
   output logic [NUM_CH-1:0]   o_ch_pending,
`ifdef SCHED_OVERRUN_CNT_EN
   output logic [8*NUM_CH-1:0] o_overrun_cnt,
`endif
   output logic                o_irq
);

   localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0]     r_presc;
   logic [31:0]       r_timebase;
   logic              r_tick;
   logic [NUM_CH-1:0] r_armed;
   logic [NUM_CH-1:0] r_periodic;
   logic [NUM_CH-1:0] r_pending;
   logic [31:0]       r_period   [NUM_CH];
   logic [31:0]       r_deadline [NUM_CH];
   logic [31:0]       r_stamp    [NUM_CH];
   logic              r_evt_valid;
   logic [CH_W-1:0]   r_evt_ch;
   logic [31:0]       r_evt_time;
   logic [CH_W-1:0]   r_rr_ptr;

   logic              w_tick_edge;
   logic [31:0]       w_tb_next;
   logic              w_slot_free;
   logic              w_found;
   logic              w_load;
   logic [CH_W-1:0]   w_winner;
   logic [CH_W-1:0]   w_cand;
   int unsigned       w_idx;
   logic [31:0]       w_cfg_per;
   logic [NUM_CH-1:0] w_cfg_hit;
   logic [NUM_CH-1:0] w_armed_d;
   logic [NUM_CH-1:0] w_periodic_d;
   logic [NUM_CH-1:0] w_pending_d;
   logic [NUM_CH-1:0] w_pend_l;
   logic [NUM_CH-1:0] w_overrun;
   logic [31:0]       w_period_d   [NUM_CH];
   logic [31:0]       w_deadline_d [NUM_CH];
   logic [31:0]       w_stamp_d    [NUM_CH];

   assign w_tick_edge = (r_presc == PW'(PRESCALE - 1));
   assign w_tb_next   = w_tick_edge ? r_timebase + 32'd1 : r_timebase;
   assign w_slot_free = !r_evt_valid || i_evt_ready;
   assign w_load      = w_slot_free && w_found;
   assign w_cfg_per   = (i_cfg_period == 32'd0) ? 32'd1 : i_cfg_period;

   // Round-robin search starts just after the last winner; k == NUM_CH wraps back to it.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = 0;
      w_cand   = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         w_idx  = (int'(unsigned'(r_rr_ptr)) + k) % NUM_CH;
         w_cand = CH_W'(w_idx);
         if (!w_found && r_pending[w_cand]) begin
            w_found  = 1'b1;
            w_winner = w_cand;
         end
      end
   end

   always_comb begin
      w_armed_d    = r_armed;
      w_periodic_d = r_periodic;
      w_pend_l     = r_pending;
      w_pending_d  = r_pending;
      w_overrun    = '0;
      w_cfg_hit    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_period_d[i]   = r_period[i];
         w_deadline_d[i] = r_deadline[i];
         w_stamp_d[i]    = r_stamp[i];
         w_cfg_hit[i]    = i_cfg_wr && (i_cfg_ch == CH_W'(i));
         if (w_load && (w_winner == CH_W'(i))) begin
            w_pend_l[i] = 1'b0;
         end
         w_pending_d[i] = w_pend_l[i];
         if (w_tick_edge && r_armed[i] && (w_tb_next == r_deadline[i])) begin
            if (w_pend_l[i]) begin
               w_overrun[i] = 1'b1;
            end else begin
               w_pending_d[i] = 1'b1;
               w_stamp_d[i]   = w_tb_next;
            end
            if (r_periodic[i]) begin
               w_deadline_d[i] = r_deadline[i] + r_period[i];
            end else begin
               w_armed_d[i] = 1'b0;
            end
         end
         // A config write to the channel discards any same-edge expiry.
         if (w_cfg_hit[i]) begin
            w_overrun[i]    = 1'b0;
            w_stamp_d[i]    = r_stamp[i];
            w_deadline_d[i] = r_deadline[i];
            if (i_cfg_enable) begin
               w_period_d[i]   = w_cfg_per;
               w_periodic_d[i] = i_cfg_periodic;
               w_deadline_d[i] = w_tb_next + w_cfg_per;
               w_armed_d[i]    = 1'b1;
               w_pending_d[i]  = w_pend_l[i];
            end else begin
               w_armed_d[i]   = 1'b0;
               w_pending_d[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_presc     <= '0;
         r_timebase  <= '0;
         r_tick      <= 1'b0;
         r_armed     <= '0;
         r_periodic  <= '0;
         r_pending   <= '0;
         r_evt_valid <= 1'b0;
         r_evt_ch    <= '0;
         r_evt_time  <= '0;
         r_rr_ptr    <= CH_W'(NUM_CH - 1);
         for (int i = 0; i < NUM_CH; i++) begin
            r_period[i]   <= '0;
            r_deadline[i] <= '0;
            r_stamp[i]    <= '0;
         end
      end else begin
         if (w_tick_edge) begin
            r_presc    <= '0;
            r_timebase <= r_timebase + 32'd1;
            r_tick     <= 1'b1;
         end else begin
            r_presc <= r_presc + PW'(1);
            r_tick  <= 1'b0;
         end
         r_armed    <= w_armed_d;
         r_periodic <= w_periodic_d;
         r_pending  <= w_pending_d;
         for (int i = 0; i < NUM_CH; i++) begin
            r_period[i]   <= w_period_d[i];
            r_deadline[i] <= w_deadline_d[i];
            r_stamp[i]    <= w_stamp_d[i];
         end
         if (w_slot_free) begin
            if (w_found) begin
               r_evt_valid <= 1'b1;
               r_evt_ch    <= w_winner;
               r_evt_time  <= r_stamp[w_winner];
               r_rr_ptr    <= w_winner;
            end else begin
               r_evt_valid <= 1'b0;
            end
         end
      end
   end

`ifdef SCHED_OVERRUN_CNT_EN
   logic [7:0] r_ovr_cnt [NUM_CH];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_ovr_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_cfg_hit[i]) begin
               r_ovr_cnt[i] <= '0;
            end else if (w_overrun[i] && (r_ovr_cnt[i] != 8'hFF)) begin
               r_ovr_cnt[i] <= r_ovr_cnt[i] + 8'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ovr
      assign o_overrun_cnt[8*g +: 8] = r_ovr_cnt[g];
   end
`else
   logic w_unused_ovr;
   assign w_unused_ovr = |w_overrun;
`endif

   assign o_tick       = r_tick;
   assign o_timebase   = r_timebase;
   assign o_evt_valid  = r_evt_valid;
   assign o_evt_ch     = r_evt_ch;
   assign o_evt_time   = r_evt_time;
   assign o_ch_pending = r_pending;
   assign o_irq        = r_evt_valid | (|r_pending);

endmodule
